rtc_bus_ctrl: RTL and testbench

- Sequences one transaction at a time on the 8-bit multiplexed address/data bus of the real-time-clock chip.
- Generates cs_n, rd_n, wr_n and the address/data select line.
- Drives the tri-state buffer's enable and input, and captures read data from the bus.
- Sits between the core-side register-access logic and the pad-level bus buffer.

---
 rtl/rtc_bus_ctrl_pkg.sv | 26 ++
 rtl/rtc_bus_ctrl_phase_timer.sv | 26 ++
 rtl/rtc_bus_ctrl.sv | 144 ++++++++++++++
 tb/tb_rtc_bus_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_ctrl_pkg.sv
// Shared definitions for the RTC multiplexed-bus controller: state encoding,
// default timing and read/write direction constants.
package rtc_bus_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        A_SU = 4'd1,
        A_ST = 4'd2,
        A_HD = 4'd3,
        GAP  = 4'd4,
        D_SU = 4'd5,
        D_ST = 4'd6,
        D_HD = 4'd7,
        DONE = 4'd8
    } rtc_state_t;

    localparam int unsigned DEF_T_SU  = 2;
    localparam int unsigned DEF_T_PW  = 4;
    localparam int unsigned DEF_T_HD  = 2;
    localparam int unsigned DEF_T_GAP = 2;
    localparam int unsigned DEF_CNT_W = 4;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/rtc_bus_ctrl_phase_timer.sv
// Loadable down-counter timing each bus phase; expire is high while the count is zero.
module rtc_phase_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Single-transaction sequencer for the RTC 8-bit multiplexed address/data bus:
// address write phase, cs_n gap, then data write or read phase.
module rtc_bus_ctrl
    import rtc_bus_ctrl_pkg::*;
#(
    parameter int unsigned T_SU  = DEF_T_SU,
    parameter int unsigned T_PW  = DEF_T_PW,
    parameter int unsigned T_HD  = DEF_T_HD,
    parameter int unsigned T_GAP = DEF_T_GAP,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_sel,
    output logic       en_ss,
    output logic [7:0] bus_out,
    input  logic [7:0] bus_in
);

    localparam logic [CNT_W-1:0] LD_SU  = CNT_W'(T_SU - 1);
    localparam logic [CNT_W-1:0] LD_PW  = CNT_W'(T_PW - 1);
    localparam logic [CNT_W-1:0] LD_HD  = CNT_W'(T_HD - 1);
    localparam logic [CNT_W-1:0] LD_GAP = CNT_W'(T_GAP - 1);

    rtc_state_t       state;
    rtc_state_t       nxt;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             expire;
    logic             rw_q;
    logic [7:0]       addr_q;
    logic [7:0]       wdata_q;
    logic             is_wr;

    rtc_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

    assign is_wr = (rw_q == RW_WRITE);

    // Next state and timer reload for the entered phase.
    always_comb begin
        nxt      = state;
        load     = 1'b0;
        load_val = '0;
        case (state)
            IDLE: if (start)  begin nxt = A_SU; load = 1'b1; load_val = LD_SU;  end
            A_SU: if (expire) begin nxt = A_ST; load = 1'b1; load_val = LD_PW;  end
            A_ST: if (expire) begin nxt = A_HD; load = 1'b1; load_val = LD_HD;  end
            A_HD: if (expire) begin nxt = GAP;  load = 1'b1; load_val = LD_GAP; end
            GAP:  if (expire) begin nxt = D_SU; load = 1'b1; load_val = LD_SU;  end
            D_SU: if (expire) begin nxt = D_ST; load = 1'b1; load_val = LD_PW;  end
            D_ST: if (expire) begin nxt = D_HD; load = 1'b1; load_val = LD_HD;  end
            D_HD: if (expire) nxt = DONE;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they appear in its first cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cs_n    <= 1'b1;
            rd_n    <= 1'b1;
            wr_n    <= 1'b1;
            ad_sel  <= 1'b1;
            en_ss   <= 1'b0;
            bus_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= '0;
            rw_q    <= RW_WRITE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= nxt;
            done  <= 1'b0;
            busy  <= (nxt != IDLE);
            rd_n  <= 1'b1;
            wr_n  <= 1'b1;
            if (state == IDLE && start) begin
                rw_q    <= rw;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state == D_ST && expire && rw_q == RW_READ) begin
                rdata <= bus_in;
            end
            case (nxt)
                A_SU: begin
                    cs_n    <= 1'b0;
                    ad_sel  <= 1'b0;
                    en_ss   <= 1'b1;
                    bus_out <= (state == IDLE) ? addr : addr_q;
                end
                A_ST: wr_n <= 1'b0;
                A_HD: ;
                GAP: begin
                    cs_n   <= 1'b1;
                    ad_sel <= 1'b1;
                    en_ss  <= 1'b0;
                end
                D_SU: begin
                    cs_n   <= 1'b0;
                    ad_sel <= 1'b1;
                    en_ss  <= is_wr;
                    if (is_wr) bus_out <= wdata_q;
                end
                D_ST: begin
                    wr_n  <= ~is_wr;
                    rd_n  <= is_wr;
                    en_ss <= is_wr;
                end
                D_HD: cs_n <= 1'b0;
                DONE: begin
                    cs_n  <= 1'b1;
                    en_ss <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    cs_n   <= 1'b1;
                    ad_sel <= 1'b1;
                    en_ss  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Directed self-checking bench for rtc_bus_ctrl: default timing instance plus a
// minimum-timing instance sharing clock and reset.
module tb_rtc_bus_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, start_f;
    logic       rw;
    logic [7:0] addr, wdata;
    logic [7:0] rd_val, rd_val_f;

    logic       busy, done, cs_n, rd_n, wr_n, ad_sel, en_ss;
    logic [7:0] rdata, bus_out, bus_in;
    logic       busy_f, done_f, cs_n_f, rd_n_f, wr_n_f, ad_sel_f, en_ss_f;
    logic [7:0] rdata_f, bus_out_f, bus_in_f;

    int n_checks = 0;
    int n_errors = 0;
    int overlap  = 0;

    always #5 clk = ~clk;

    assign bus_in   = !rd_n   ? rd_val   : 8'hEE;
    assign bus_in_f = !rd_n_f ? rd_val_f : 8'hEE;

    rtc_bus_ctrl u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .ad_sel(ad_sel), .en_ss(en_ss), .bus_out(bus_out), .bus_in(bus_in)
    );

    rtc_bus_ctrl #(.T_SU(1), .T_PW(1), .T_HD(1), .T_GAP(1), .CNT_W(4)) u_fast (
        .clk(clk), .reset_n(reset_n), .start(start_f), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy_f), .done(done_f), .rdata(rdata_f), .cs_n(cs_n_f), .rd_n(rd_n_f),
        .wr_n(wr_n_f), .ad_sel(ad_sel_f), .en_ss(en_ss_f), .bus_out(bus_out_f), .bus_in(bus_in_f)
    );

    always @(negedge clk) begin
        if ((!rd_n && en_ss) || (!rd_n_f && en_ss_f)) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle c is the c-th cycle after the acceptance edge; sampled at its negedge.
    task automatic run_txn(input logic t_rw, input logic [7:0] t_addr, input logic [7:0] t_wdata,
                           input logic [31:0] extra, input logic [7:0] rd_before,
                           input logic [7:0] rd_after);
        logic wr, in_a, in_d, stb_a, stb_d;
        int   dcyc;
        wr = (t_rw == 1'b0);
        @(negedge clk);
        start = 1'b1; rw = t_rw; addr = t_addr; wdata = t_wdata;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            in_a  = (c >= 1 && c <= 8);
            in_d  = (c >= 11 && c <= 18);
            stb_a = (c >= 3 && c <= 6);
            stb_d = (c >= 13 && c <= 16);
            check($sformatf("cs_n@%0d", c), cs_n, !(in_a || in_d));
            check($sformatf("wr_n@%0d", c), wr_n, !(stb_a || (wr && stb_d)));
            check($sformatf("rd_n@%0d", c), rd_n, !(!wr && stb_d));
            check($sformatf("ad_sel@%0d", c), ad_sel, !in_a);
            check($sformatf("en_ss@%0d", c), en_ss, in_a || (wr && in_d));
            check($sformatf("busy@%0d", c), busy, c <= 19);
            check($sformatf("done@%0d", c), done, c == 19);
            if (in_a) check($sformatf("bus_out_a@%0d", c), bus_out, t_addr);
            if (wr && in_d) check($sformatf("bus_out_d@%0d", c), bus_out, t_wdata);
            if (c == 16) check("rdata_pre", rdata, rd_before);
            if (c == 17 || c == 20) check($sformatf("rdata@%0d", c), rdata, rd_after);
            if (c == 1) begin addr = ~t_addr; wdata = ~t_wdata; rw = ~t_rw; end
            start = extra[c];
        end
        @(negedge clk);
        start = 1'b0;
        check("busy@21", busy, extra[20]);
        if (extra[20]) begin
            dcyc = 0;
            for (int c = 22; c <= 60; c++) begin
                @(negedge clk);
                if (done) begin dcyc = c; break; end
            end
            check("second_done_cycle", dcyc, 39);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int dcyc, first_rd, seen_done;
        reset_n = 1'b0; start = 1'b0; start_f = 1'b0; rw = 1'b0;
        addr = '0; wdata = '0; rd_val = 8'h37; rd_val_f = 8'hA5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_cs_n", cs_n, 1);
        check("rst_rd_n", rd_n, 1);
        check("rst_wr_n", wr_n, 1);
        check("rst_en_ss", en_ss, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rdata", rdata, 8'h00);

        run_txn(1'b0, 8'h21, 8'h5A, 32'h0, 8'h00, 8'h00);
        run_txn(1'b1, 8'h22, 8'h00, 32'h0, 8'h00, 8'h37);
        run_txn(1'b0, 8'h23, 8'hC3, 32'h0, 8'h37, 8'h37);
        // extra pulses in cycles 5, 19 (ignored) and 20 (accepted)
        run_txn(1'b0, 8'h30, 8'h0F, (32'h1 << 5) | (32'h1 << 19) | (32'h1 << 20), 8'h37, 8'h37);

        // reset during the data strobe of a write
        @(negedge clk);
        start = 1'b1; rw = 1'b0; addr = 8'h40; wdata = 8'h99;
        @(posedge clk);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("pre_rst_wr_n", wr_n, 0);
        #1 reset_n = 1'b0;
        #1;
        check("arst_wr_n", wr_n, 1);
        check("arst_cs_n", cs_n, 1);
        check("arst_en_ss", en_ss, 0);
        check("arst_busy", busy, 0);
        seen_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        reset_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("arst_no_done", seen_done, 0);
        check("arst_rdata", rdata, 8'h00);

        rd_val = 8'h9C;
        run_txn(1'b1, 8'h41, 8'h00, 32'h0, 8'h00, 8'h9C);

        // minimum timing instance: read
        @(negedge clk);
        start_f = 1'b1; rw = 1'b1; addr = 8'h44;
        @(posedge clk);
        dcyc = 0; first_rd = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start_f = 1'b0;
            if (!rd_n_f && first_rd == 0) first_rd = c;
            if (done_f) begin dcyc = c; break; end
        end
        check("fast_done_cycle", dcyc, 8);
        check("fast_rd_cycle", first_rd, 6);
        check("fast_rdata", rdata_f, 8'hA5);
        @(negedge clk);
        check("fast_busy_end", busy_f, 0);

        check("no_overlap", overlap, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
